// File: rtl/marquee_scroller.sv
// marquee_scroller: scrolls, holds or blinks a message of up to MAX_LEN glyphs across N_DIG 7-seg digits
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   i_enable     1 = run, 0 = blank display and hold in RESTART
//   i_msg_sel    message number forwarded to the character source
//   i_mode       0 SCROLL, 1 STATIC, 2 BLINK, 3 STATIC
//   i_msg_len    length of the selected message in characters
//   o_char_idx   character index requested from the source (combinational lookup)
//   i_char_seg   glyph for (i_msg_sel, o_char_idx), valid in the same cycle
//   o_display    segment data, slot k = o_display[7k+6:7k]
//   o_pass_done  one-clk pulse when a SCROLL pass wraps
//   o_busy       1 while enabled and not in RESTART
module marquee_scroller #(
    parameter int N_DIG   = 4,
    parameter int DIVISOR = 9000000,
    parameter int MAX_LEN = 24,
    parameter int GAP     = 4,
    parameter int N_MSG   = 8,
    parameter int IDXW    = $clog2(MAX_LEN + GAP),
    parameter int SELW    = $clog2(N_MSG)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_enable,
    input  logic [SELW-1:0]    i_msg_sel,
    input  logic [1:0]         i_mode,
    input  logic [IDXW-1:0]    i_msg_len,
    output logic [IDXW-1:0]    o_char_idx,
    input  logic [6:0]         i_char_seg,
    output logic [7*N_DIG-1:0] o_display,
    output logic               o_pass_done,
    output logic               o_busy
);
    localparam int CW = $clog2(DIVISOR);

    typedef enum logic [1:0] {S_RESTART, S_SCROLL, S_LOAD, S_HOLD} state_t;

    state_t             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic [IDXW-1:0]    r_pos;
    logic               r_phase;
    logic               r_pass;
    logic [SELW-1:0]    r_sel;
    logic [1:0]         r_mode;
    logic [7*N_DIG-1:0] r_buf, w_shift, w_load;
    logic               w_tick, w_restart, w_wrap, w_load_end;
    logic [IDXW-1:0]    w_eff;
    logic [IDXW:0]      w_last;
    logic [6:0]         w_char;

    assign w_tick     = r_cnt == CW'(DIVISOR - 1);
    // RESTART itself latches the new selection, so a mismatch there is not a new restart
    assign w_restart  = !i_enable || (r_state != S_RESTART && (r_sel != i_msg_sel || r_mode != i_mode));
    assign w_eff      = (i_msg_len > IDXW'(MAX_LEN)) ? IDXW'(MAX_LEN) : i_msg_len;
    assign w_last     = {1'b0, w_eff} + (IDXW+1)'(GAP - 1);
    // >= keeps pos bounded if msg_len shrinks mid-pass
    assign w_wrap     = {1'b0, r_pos} >= w_last;
    assign w_load_end = r_pos == IDXW'(N_DIG - 1);
    assign w_char     = (r_pos < w_eff) ? i_char_seg : 7'd0;
    // gap slots past MAX_LEN never reach the character source
    assign o_char_idx = (r_pos < IDXW'(MAX_LEN)) ? r_pos : '0;
    assign o_display  = (r_state == S_HOLD && r_mode == 2'd2 && r_phase) ? '0 : r_buf;
    assign o_pass_done = r_pass;
    assign o_busy     = i_enable && r_state != S_RESTART;

    always_comb begin
        w_shift = r_buf;
        for (int k = 0; k < N_DIG - 1; k++)
            w_shift[7*k +: 7] = r_buf[7*(k+1) +: 7];
        w_shift[7*(N_DIG-1) +: 7] = w_char;
    end

    // LOAD places char j into slot N_DIG-1-j so the message start sits in the top slot
    always_comb begin
        w_load = r_buf;
        for (int k = 0; k < N_DIG; k++)
            if (r_pos == IDXW'(N_DIG - 1 - k))
                w_load[7*k +: 7] = w_char;
    end

    always_comb begin
        w_next = r_state;
        if (w_restart)
            w_next = S_RESTART;
        else if (r_state == S_RESTART)
            w_next = (i_mode == 2'd0) ? S_SCROLL : S_LOAD;
        else if (r_state == S_LOAD && w_load_end)
            w_next = S_HOLD;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            r_state <= S_RESTART;
        else
            r_state <= w_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf   <= '0;
            r_pos   <= '0;
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_pass  <= 1'b0;
            r_sel   <= '0;
            r_mode  <= '0;
        end else if (w_restart) begin
            r_buf   <= '0;
            r_pos   <= '0;
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_cnt  <= w_tick ? '0 : r_cnt + 1'b1;
            r_pass <= r_state == S_SCROLL && w_tick && w_wrap;
            if (r_state == S_RESTART) begin
                r_sel  <= i_msg_sel;
                r_mode <= i_mode;
            end
            if (r_state == S_SCROLL && w_tick) begin
                r_buf <= w_shift;
                r_pos <= w_wrap ? '0 : r_pos + 1'b1;
            end
            if (r_state == S_LOAD) begin
                r_buf <= w_load;
                r_pos <= w_load_end ? '0 : r_pos + 1'b1;
            end
            if (r_state == S_HOLD && w_tick)
                r_phase <= ~r_phase;
        end
    end
endmodule

// File: tb/tb_marquee_scroller.sv
// tb_marquee_scroller: randomized bench for marquee_scroller against a closed-form behavioural model
module tb_marquee_scroller;
    localparam int N  = 4;
    localparam int D  = 4;
    localparam int ML = 24;
    localparam int G  = 4;
    localparam int NM = 8;
    localparam int IW = 5;
    localparam int SW = 3;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          en = 0;
    logic [SW-1:0] sel = 0;
    logic [1:0]    mode = 0;
    logic [IW-1:0] len = 0;
    logic [IW-1:0] cidx;
    logic [6:0]    cseg;
    logic [7*N-1:0] disp;
    logic          pass, busy;
    logic [6:0]    rom [NM][32];
    int            n_tests = 0;
    int            n_fails = 0;

    logic          m_in_r;
    int            m_n;
    logic [SW-1:0] m_sel;
    logic [1:0]    m_mode;
    int            m_eff;

    always #5 clk = ~clk;

    assign cseg = rom[sel][cidx];

    marquee_scroller #(.N_DIG(N), .DIVISOR(D), .MAX_LEN(ML), .GAP(G), .N_MSG(NM)) dut (
        .clk(clk), .rst_n(rst_n), .i_enable(en), .i_msg_sel(sel), .i_mode(mode),
        .i_msg_len(len), .o_char_idx(cidx), .i_char_seg(cseg), .o_display(disp),
        .o_pass_done(pass), .o_busy(busy)
    );

    // model state: whether in RESTART, and cycles elapsed since the RESTART cycle
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            m_in_r <= 1'b1;
            m_n    <= 0;
            m_sel  <= '0;
            m_mode <= '0;
            m_eff  <= 0;
        end else if (!en) begin
            m_in_r <= 1'b1;
            m_n    <= 0;
        end else if (m_in_r) begin
            m_in_r <= 1'b0;
            m_n    <= 1;
            m_sel  <= sel;
            m_mode <= mode;
            m_eff  <= (int'(len) > ML) ? ML : int'(len);
        end else if (sel != m_sel || mode != m_mode) begin
            m_in_r <= 1'b1;
            m_n    <= 0;
        end else
            m_n <= m_n + 1;

    function automatic logic [6:0] glyph(input int p);
        return (p < m_eff) ? rom[m_sel][p] : 7'd0;
    endfunction

    function automatic logic [7*N-1:0] exp_disp();
        logic [7*N-1:0] d = '0;
        int t, idx, ld;
        if (m_in_r) return '0;
        if (m_mode == 2'd0) begin
            t = m_n / D;
            for (int k = 0; k < N; k++) begin
                idx = t - N + k;
                if (idx >= 0) d[7*k +: 7] = glyph(idx % (m_eff + G));
            end
        end else begin
            ld = (m_n - 1 < N) ? m_n - 1 : N;
            for (int j = 0; j < ld; j++) d[7*(N-1-j) +: 7] = glyph(j);
            if (m_mode == 2'd2 && m_n > N && ((m_n / D - (N + 1) / D) % 2 == 1)) d = '0;
        end
        return d;
    endfunction

    function automatic logic exp_pass();
        return !m_in_r && m_mode == 2'd0 && m_n % D == 0 && m_n / D > 0 && (m_n / D) % (m_eff + G) == 0;
    endfunction

    // -1: index unconstrained, only the MAX_LEN bound applies
    function automatic int exp_ci();
        int p;
        if (m_in_r) return 0;
        if (m_mode == 2'd0) begin
            p = (m_n / D) % (m_eff + G);
            return (p < ML) ? p : -1;
        end
        return (m_n <= N) ? m_n - 1 : -1;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic wait_n(input int k);
        int b = 0;
        @(negedge clk);
        while (!((k == 0) ? m_in_r : (!m_in_r && m_n == k)) && b < 300) begin
            @(negedge clk);
            b++;
        end
        if (b >= 300) begin
            n_tests++;
            n_fails++;
            $display("FAIL wait_n timeout waiting for cycle %0d", k);
        end
    endtask

    task automatic start(input int s, input int m, input int l);
        @(posedge clk);
        #2 en = 0;
        @(posedge clk);
        #2;
        en   = 1;
        sel  = SW'(s);
        mode = 2'(m);
        len  = IW'(l);
    endtask

    initial begin
        int ci, ns, nm;
        logic ne;
        for (int i = 0; i < NM; i++)
            for (int p = 0; p < 32; p++)
                rom[i][p] = 7'($urandom_range(1, 127));
        rom[0][0] = 7'd118; rom[0][1] = 7'd63;  rom[0][2] = 7'd56;  rom[0][3] = 7'd119;
        rom[1][0] = 7'd57;  rom[1][1] = 7'd118; rom[1][2] = 7'd63;  rom[1][3] = 7'd63;
        rom[1][4] = 7'd109; rom[1][5] = 7'd121;
        rom[2][0] = 7'd111; rom[2][1] = 7'd63;
        rom[3][0] = 7'd115; rom[3][1] = 7'd56;  rom[3][2] = 7'd119; rom[3][3] = 7'd110;
        fork
            forever begin
                @(negedge clk);
                check("display", 32'(disp), 32'(exp_disp()));
                check("pass_done", 32'(pass), 32'(exp_pass()));
                check("busy", 32'(busy), 32'(en && !m_in_r));
                ci = exp_ci();
                if (ci >= 0) check("char_idx", 32'(cidx), ci);
                check("char_idx_range", 32'(cidx < ML), 1);
            end
        join_none
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        check("reset_display", 32'(disp), 0);
        check("reset_pass", 32'(pass), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_char_idx", 32'(cidx), 0);

        start(0, 0, 4);
        wait_n(16);
        check("hola_4ticks", 32'(disp), 32'({7'd119, 7'd56, 7'd63, 7'd118}));
        wait_n(31);
        check("hola_pass_before", 32'(pass), 0);
        wait_n(32);
        check("hola_pass", 32'(pass), 1);
        check("hola_blank", 32'(disp), 0);
        wait_n(33);
        check("hola_pass_after", 32'(pass), 0);

        start(0, 0, 4);
        wait_n(8);
        @(posedge clk);
        #2 sel = 3;
        wait_n(0);
        check("sel_change_display", 32'(disp), 0);
        check("sel_change_idx", 32'(cidx), 0);
        wait_n(3);
        check("play_before_tick", 32'(disp), 0);
        wait_n(4);
        check("play_first", 32'(disp), 32'({7'd115, 7'd0, 7'd0, 7'd0}));

        start(1, 1, 6);
        wait_n(5);
        check("choose_loaded", 32'(disp), 32'({7'd57, 7'd118, 7'd63, 7'd63}));
        wait_n(85);
        check("choose_hold", 32'(disp), 32'({7'd57, 7'd118, 7'd63, 7'd63}));

        start(2, 2, 2);
        wait_n(5);
        check("go_loaded", 32'(disp), 32'({7'd111, 7'd63, 7'd0, 7'd0}));
        wait_n(8);
        check("go_blink_off", 32'(disp), 0);
        wait_n(12);
        check("go_blink_on", 32'(disp), 32'({7'd111, 7'd63, 7'd0, 7'd0}));

        start(5, 0, 0);
        wait_n(16);
        check("empty_pass", 32'(pass), 1);
        wait_n(32);
        check("empty_pass2", 32'(pass), 1);
        check("empty_blank", 32'(disp), 0);

        start(4, 0, 31);
        wait_n(130);

        start(0, 0, 4);
        wait_n(10);
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        check("async_rst_display", 32'(disp), 0);
        check("async_rst_pass", 32'(pass), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_idx", 32'(cidx), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        wait_n(4);
        check("after_rst_first", 32'(disp), 32'({7'd118, 7'd0, 7'd0, 7'd0}));
        wait_n(10);
        @(posedge clk);
        #2 en = 0;
        @(negedge clk);
        check("disable_busy", 32'(busy), 0);
        @(negedge clk);
        check("disable_display", 32'(disp), 0);

        for (int s = 0; s < 40; s++) begin
            @(posedge clk);
            #2;
            ns = $urandom_range(0, NM - 1);
            nm = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            ne = $urandom_range(0, 9) != 0;
            if (!(ne && en && SW'(ns) == sel && 2'(nm) == mode))
                len = ($urandom_range(0, 3) == 0) ? IW'($urandom_range(25, 31)) : IW'($urandom_range(0, 12));
            sel  = SW'(ns);
            mode = 2'(nm);
            en   = ne;
            repeat ($urandom_range(5, 120)) @(posedge clk);
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end
endmodule
